// File: rtl/alu_pkg.sv
// Shared types, constants and the non-divide ALU function for the arbitrated ALU controller.
package alu_pkg;

  localparam int unsigned ALU_W      = 4;
  localparam int unsigned ALU_RES_W  = 5;
  localparam int unsigned DIV_CYCLES = 4;

  typedef enum logic [2:0] {
    OpAdd  = 3'b000,
    OpSub  = 3'b001,
    OpDiv  = 3'b010,
    OpLand = 3'b011,
    OpAnd  = 3'b100,
    OpOr   = 3'b101,
    OpNand = 3'b110,
    OpXnor = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } alu_state_e;

  // Single-cycle ops; the divider is sequenced separately by the controller.
  function automatic logic [ALU_RES_W-1:0] alu_simple(input alu_op_e op,
                                                      input logic [ALU_W-1:0] a,
                                                      input logic [ALU_W-1:0] b);
    logic [ALU_RES_W-1:0] res;
    res = '0;
    case (op)
      OpAdd:   res = {1'b0, a} + {1'b0, b};
      OpSub:   res = {1'b0, a} - {1'b0, b};
      OpLand:  res = {4'b0000, (a != '0) && (b != '0)};
      OpAnd:   res = {1'b0, a & b};
      OpOr:    res = {1'b0, a | b};
      OpNand:  res = {1'b0, ~(a & b)};
      OpXnor:  res = {1'b0, ~(a ^ b)};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first set request after the last grant, wrapping.
module alu_rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  always_comb begin
    int unsigned j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      j = (32'(last) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// Round-robin arbitrated 4-bit ALU with a restoring divider and one tagged response channel.
// Optional ALU_ARB_DIVZ_EN: divide-by-zero short-cuts to rsp_y = 0 and raises rsp_err.
module alu_arb_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [3*NREQ-1:0]      req_sel,
  input  logic [4*NREQ-1:0]      req_a,
  input  logic [4*NREQ-1:0]      req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ALU_RES_W-1:0]   rsp_y,
  output logic [IDW-1:0]         rsp_id
`ifdef ALU_ARB_DIVZ_EN
  ,
  output logic                   rsp_err
`endif
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  alu_state_e           state_q, state_d;
  logic [IDW-1:0]       last_q, last_d;
  alu_op_e              op_q, op_d;
  logic [ALU_W-1:0]     a_q, a_d, b_q, b_d;
  logic [ALU_W-1:0]     rem_q, rem_d, quo_q, quo_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ALU_RES_W-1:0] y_q, y_d;
  logic [IDW-1:0]       id_q, id_d;
`ifdef ALU_ARB_DIVZ_EN
  logic                 err_q, err_d;
`endif

  logic [NREQ-1:0]      pick_gnt;
  logic [IDW-1:0]       pick_idx;
  logic                 pick_any;
  logic [2:0]           win_sel;
  logic [ALU_W-1:0]     win_a, win_b;

  logic [ALU_W:0]       div_shift;
  logic [ALU_W+1:0]     div_diff;
  logic                 div_ge;
  logic [ALU_W-1:0]     rem_next, quo_next;

  alu_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // One-hot OR-mux of the winner's operation fields.
  always_comb begin
    win_sel = '0;
    win_a   = '0;
    win_b   = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_gnt[i]) begin
        win_sel = win_sel | req_sel[3*i +: 3];
        win_a   = win_a | req_a[4*i +: 4];
        win_b   = win_b | req_b[4*i +: 4];
      end
    end
  end

  // Restoring divide step: quo_q shifts dividend bits out the top, quotient bits in the bottom.
  always_comb begin
    div_shift = {rem_q, quo_q[ALU_W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, b_q};
    div_ge    = ~div_diff[ALU_W+1];
    rem_next  = div_ge ? div_diff[ALU_W-1:0] : div_shift[ALU_W-1:0];
    quo_next  = {quo_q[ALU_W-2:0], div_ge};
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    id_d      = id_q;
`ifdef ALU_ARB_DIVZ_EN
    err_d     = err_q;
`endif
    req_ready = '0;

    case (state_q)
      StIdle: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          last_d    = pick_idx;
          id_d      = pick_idx;
          op_d      = alu_op_e'(win_sel);
          a_d       = win_a;
          b_d       = win_b;
          rem_d     = '0;
          quo_d     = win_a;
          cnt_d     = '0;
`ifdef ALU_ARB_DIVZ_EN
          err_d     = 1'b0;
`endif
          state_d   = StExec;
        end
      end
      StExec: begin
`ifdef ALU_ARB_DIVZ_EN
        if (op_q == OpDiv && b_q == '0) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else
`endif
        if (op_q == OpDiv) begin
          rem_d = rem_next;
          quo_d = quo_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
            y_d     = {1'b0, quo_next};
            state_d = StResp;
          end
        end else begin
          y_d     = alu_simple(op_q, a_q, b_q);
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= IDW'(NREQ - 1);
      op_q    <= OpAdd;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      id_q    <= '0;
`ifdef ALU_ARB_DIVZ_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      id_q    <= id_d;
`ifdef ALU_ARB_DIVZ_EN
      err_q   <= err_d;
`endif
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_y     = y_q;
  assign rsp_id    = id_q;
`ifdef ALU_ARB_DIVZ_EN
  assign rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Directed-vector bench for alu_arb_ctrl; builds with or without ALU_ARB_DIVZ_EN.
module tb_alu_arb_ctrl;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_sel;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_y;
  logic [1:0]  rsp_id;
`ifdef ALU_ARB_DIVZ_EN
  logic        rsp_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arb_ctrl #(
    .NREQ (NREQ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_y     (rsp_y),
    .rsp_id    (rsp_id)
`ifdef ALU_ARB_DIVZ_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  typedef struct {
    int         id;
    logic [2:0] sel;
    logic [3:0] a;
    logic [3:0] b;
    logic [4:0] y;
  } vec_t;

  vec_t vecs [11] = '{
    '{0, 3'b000, 4'hF, 4'hF, 5'b11110},
    '{1, 3'b001, 4'h0, 4'h1, 5'b11111},
    '{2, 3'b011, 4'h0, 4'h5, 5'b00000},
    '{3, 3'b011, 4'h3, 4'h2, 5'b00001},
    '{0, 3'b110, 4'hF, 4'hF, 5'b00000},
    '{1, 3'b111, 4'hA, 4'hA, 5'b01111},
    '{2, 3'b101, 4'hA, 4'h5, 5'b01111},
    '{3, 3'b100, 4'hC, 4'hA, 5'b01000},
    '{0, 3'b010, 4'hF, 4'h2, 5'b00111},
    '{1, 3'b010, 4'h7, 4'h7, 5'b00001},
    '{2, 3'b110, 4'hA, 4'h5, 5'b01111}
  };

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int id, input logic [2:0] sel, input logic [3:0] a,
                       input logic [3:0] b);
    req_sel[3*id +: 3] = sel;
    req_a[4*id +: 4]   = a;
    req_b[4*id +: 4]   = b;
    req_valid[id]      = 1'b1;
  endtask

  // Returns at the falling edge of the cycle after the handshake edge.
  task automatic send(input int id, input logic [2:0] sel, input logic [3:0] a,
                      input logic [3:0] b);
    int t;
    @(negedge clk);
    drive(id, sel, a, b);
    t = 0;
    #1;
    while (!req_ready[id] && t < 30) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("grant", 32'(req_ready[id]), 32'd1);
    if (req_ready[id]) @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic [4:0] y, input logic [1:0] id,
                            input int lat_exp, input logic err);
    int lat;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
    check({tag, "_y"}, 32'(rsp_y), 32'(y));
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
`ifdef ALU_ARB_DIVZ_EN
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
`else
    if (err) check({tag, "_err"}, 32'd0, 32'd1);
`endif
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    req_valid = '0;
    req_sel   = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_y", 32'(rsp_y), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
`ifdef ALU_ARB_DIVZ_EN
    check("rst_err", 32'(rsp_err), 32'd0);
`endif
    rst = 1'b0;

    send(0, 3'b000, 4'd4, 4'd3);
    expect_rsp("add", 5'b00111, 2'd0, 2, 1'b0);
    send(2, 3'b001, 4'd3, 4'd4);
    expect_rsp("sub", 5'b11111, 2'd2, 2, 1'b0);
    send(2, 3'b010, 4'd13, 4'd3);
    expect_rsp("div", 5'b00100, 2'd2, 5, 1'b0);

    send(1, 3'b010, 4'd9, 4'd0);
`ifdef ALU_ARB_DIVZ_EN
    expect_rsp("divz", 5'b00000, 2'd1, 2, 1'b1);
`else
    expect_rsp("divz", 5'b01111, 2'd1, 5, 1'b0);
`endif

    foreach (vecs[i]) begin
      send(vecs[i].id, vecs[i].sel, vecs[i].a, vecs[i].b);
      expect_rsp($sformatf("vec%0d", i), vecs[i].y, 2'(vecs[i].id),
                 (vecs[i].sel == 3'b010) ? 5 : 2, 1'b0);
    end

    // Backpressure: response held, a competing requester must wait.
    rsp_ready = 1'b0;
    send(1, 3'b000, 4'd2, 4'd3);
    drive(3, 3'b101, 4'hA, 4'h5);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", 32'(lat), 32'd2);
    for (int c = 0; c < 6; c++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_y", 32'(rsp_y), 32'd5);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_done", 32'(rsp_valid), 32'd0);
    check("bp_next_gnt", 32'(req_ready), 32'b1000);
    @(posedge clk);
    @(negedge clk);
    req_valid[3] = 1'b0;
    expect_rsp("bp_next", 5'b01111, 2'd3, 2, 1'b0);

    // Round robin with all requesters valid, starting from reset priority.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) drive(i, 3'b100, 4'hF, 4'h5);
    for (int r = 0; r < 5; r++) begin
      lat = 0;
      while (!rsp_valid && lat < 20) begin
        check("rr_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        @(negedge clk);
        lat++;
      end
      check($sformatf("rr%0d_id", r), 32'(rsp_id), 32'(r % NREQ));
      check($sformatf("rr%0d_y", r), 32'(rsp_y), 32'd5);
      @(negedge clk);
    end
    req_valid = '0;

    // Reset during a divide: no response, priority returns to requester 0.
    send(2, 3'b010, 4'hF, 4'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("post_rst_quiet", 32'(rsp_valid), 32'd0);
      @(negedge clk);
    end
    drive(0, 3'b100, 4'hC, 4'hA);
    drive(3, 3'b100, 4'hF, 4'hF);
    #1;
    check("post_rst_gnt", 32'(req_ready), 32'b0001);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    expect_rsp("post_rst", 5'b01000, 2'd0, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
